serial_bus_arbiter: RTL and testbench

- Central arbiter for the serial system bus.
- Receives bus_req from every master out-port and drives each port's bus_grant and split_en.
- Grants are round-robin; slaves can split transactions, and a split master is resumed with top priority when its slave becomes ready.
- Sits between the master ports and the address/data muxes; grant_id drives the mux select.

---
 rtl/serial_bus_arbiter_if.sv | 27 ++
 rtl/serial_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bus_arbiter_if.sv
// Bundle of request, split and grant signals between the bus masters and the
// central arbiter. The arbiter connects through the slave modport.
interface serial_bus_arbiter_if #(
    parameter int MASTER_NO = 2,
    parameter int SLAVE_NO  = 3,
    parameter int MID_W     = (MASTER_NO > 2) ? $clog2(MASTER_NO) : 1
);
    logic [MASTER_NO-1:0] bus_req;
    logic [MASTER_NO-1:0] tx_done;
    logic                 split_on;
    logic [SLAVE_NO-1:0]  split_slave;
    logic [SLAVE_NO-1:0]  s_ready;
    logic [MASTER_NO-1:0] bus_grant;
    logic [MID_W-1:0]     grant_id;
    logic [MASTER_NO-1:0] split_en;
    logic                 bus_busy;

    modport master (
        output bus_req, tx_done, split_on, split_slave, s_ready,
        input  bus_grant, grant_id, split_en, bus_busy
    );

    modport slave (
        input  bus_req, tx_done, split_on, split_slave, s_ready,
        output bus_grant, grant_id, split_en, bus_busy
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with single-outstanding split support.
// A parked master is resumed with top priority once its slave reports ready.
//
// state   | meaning
// IDLE    | bus free, arbitrate (split resume first, then round-robin)
// GRANT   | one master owns the bus until tx_done, request drop or split
// RELEASE | one dead turnaround cycle, no grant
module serial_bus_arbiter #(
    parameter int MASTER_NO = 2,
    parameter int SLAVE_NO  = 3,
    parameter int MID_W     = (MASTER_NO > 2) ? $clog2(MASTER_NO) : 1
) (
    input logic              clk,
    input logic              rst,
    serial_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MASTER_NO-1:0] grant_q, grant_d;
    logic [MID_W-1:0]     gid_q, gid_d;
    logic [MASTER_NO-1:0] split_en_q, split_en_d;
    logic                 busy_q, busy_d;
    logic [MID_W-1:0]     rr_q, rr_d;
    logic                 pending_q, pending_d;
    logic [MID_W-1:0]     parked_q, parked_d;
    logic [SLAVE_NO-1:0]  sslave_q, sslave_d;
    logic                 resume_q, resume_d;

    logic [MASTER_NO-1:0] eligible;
    logic                 rr_found;
    logic [MID_W-1:0]     rr_idx;
    int                   cand;

    function automatic logic [MID_W-1:0] next_ptr(input logic [MID_W-1:0] idx);
        if (int'(idx) >= MASTER_NO - 1) begin
            return '0;
        end
        return idx + MID_W'(1);
    endfunction

    // A parked master keeps requesting but must not win ordinary arbitration.
    assign eligible = bus.bus_req & ~split_en_q;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int i = 0; i < MASTER_NO; i++) begin
            cand = (int'(rr_q) + i) % MASTER_NO;
            if (!rr_found && eligible[cand]) begin
                rr_found = 1'b1;
                rr_idx   = MID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gid_d      = gid_q;
        split_en_d = split_en_q;
        busy_d     = busy_q;
        rr_d       = rr_q;
        pending_d  = pending_q;
        parked_d   = parked_q;
        sslave_d   = sslave_q;
        resume_d   = resume_q;

        // Split bookkeeping runs in every state; an abandoned park is dropped.
        if (pending_q) begin
            if (!bus.bus_req[parked_q]) begin
                pending_d            = 1'b0;
                resume_d             = 1'b0;
                split_en_d[parked_q] = 1'b0;
            end else if ((bus.s_ready & sslave_q) != '0) begin
                resume_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (resume_q && pending_q && bus.bus_req[parked_q]) begin
                    grant_d              = '0;
                    grant_d[parked_q]    = 1'b1;
                    gid_d                = parked_q;
                    busy_d               = 1'b1;
                    split_en_d[parked_q] = 1'b0;
                    pending_d            = 1'b0;
                    resume_d             = 1'b0;
                    rr_d                 = next_ptr(parked_q);
                    state_d              = GRANT;
                end else if (rr_found) begin
                    grant_d         = '0;
                    grant_d[rr_idx] = 1'b1;
                    gid_d           = rr_idx;
                    busy_d          = 1'b1;
                    rr_d            = next_ptr(rr_idx);
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (bus.tx_done[gid_q] || !bus.bus_req[gid_q]) begin
                    grant_d = '0;
                    gid_d   = '0;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end else if (bus.split_on && !pending_q) begin
                    pending_d         = 1'b1;
                    parked_d          = gid_q;
                    sslave_d          = bus.split_slave;
                    resume_d          = 1'b0;
                    split_en_d[gid_q] = 1'b1;
                    grant_d           = '0;
                    gid_d             = '0;
                    busy_d            = 1'b0;
                    state_d           = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                gid_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                gid_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gid_q      <= '0;
            split_en_q <= '0;
            busy_q     <= 1'b0;
            rr_q       <= '0;
            pending_q  <= 1'b0;
            parked_q   <= '0;
            sslave_q   <= '0;
            resume_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gid_q      <= gid_d;
            split_en_q <= split_en_d;
            busy_q     <= busy_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
            parked_q   <= parked_d;
            sslave_q   <= sslave_d;
            resume_q   <= resume_d;
        end
    end

    assign bus.bus_grant = grant_q;
    assign bus.grant_id  = gid_q;
    assign bus.split_en  = split_en_q;
    assign bus.bus_busy  = busy_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an owner/parked model.
module tb_serial_bus_arbiter;
    localparam int MN = 3;
    localparam int SN = 3;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_bus_arbiter_if #(.MASTER_NO(MN), .SLAVE_NO(SN), .MID_W(MW)) bif();

    serial_bus_arbiter #(.MASTER_NO(MN), .SLAVE_NO(SN), .MID_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: who owns the bus, whether a turnaround cycle is pending,
    // who is parked on which slave, and whether that slave became ready.
    int            m_owner  = -1;
    int            m_ptr    = 0;
    int            m_parked = -1;
    bit            m_dead   = 1'b0;
    bit            m_rdy    = 1'b0;
    logic [SN-1:0] m_pslv   = '0;
    logic [MN-1:0] drop_next = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int old_owner;
        int old_parked;
        bit old_rdy;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_parked = -1;
            m_dead = 1'b0; m_rdy = 1'b0; m_pslv = '0;
            return;
        end
        old_owner  = m_owner;
        old_parked = m_parked;
        old_rdy    = m_rdy;
        if (old_parked >= 0) begin
            if (!bif.bus_req[old_parked]) begin
                m_parked = -1;
                m_rdy    = 1'b0;
            end else if ((bif.s_ready & m_pslv) != '0) begin
                m_rdy = 1'b1;
            end
        end
        if (old_owner >= 0) begin
            if (bif.tx_done[old_owner] || !bif.bus_req[old_owner]) begin
                m_owner = -1;
                m_dead  = 1'b1;
            end else if (bif.split_on && old_parked < 0) begin
                m_parked = old_owner;
                m_pslv   = bif.split_slave;
                m_rdy    = 1'b0;
                m_owner  = -1;
                m_dead   = 1'b1;
            end
        end else if (m_dead) begin
            m_dead = 1'b0;
        end else if (old_rdy && old_parked >= 0 && bif.bus_req[old_parked]) begin
            m_owner  = old_parked;
            m_parked = -1;
            m_rdy    = 1'b0;
            m_ptr    = (old_parked + 1) % MN;
        end else begin
            for (int i = 0; i < MN; i++) begin
                int m;
                m = (m_ptr + i) % MN;
                if (bif.bus_req[m] && m != old_parked) begin
                    m_owner = m;
                    m_ptr   = (m + 1) % MN;
                    break;
                end
            end
        end
    endtask

    task automatic compare();
        logic [MN-1:0] eg;
        logic [MN-1:0] es;
        eg = '0;
        es = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_parked >= 0) es[m_parked] = 1'b1;
        chk("model_grant", 32'(bif.bus_grant), 32'(eg));
        chk("model_grant_id", 32'(bif.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("model_split_en", 32'(bif.split_en), 32'(es));
        chk("model_busy", 32'(bif.bus_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [MN-1:0] g, input logic [MW-1:0] id,
                       input logic [MN-1:0] s, input logic b);
        chk({name, "_grant"}, 32'(bif.bus_grant), 32'(g));
        chk({name, "_id"}, 32'(bif.grant_id), 32'(id));
        chk({name, "_split"}, 32'(bif.split_en), 32'(s));
        chk({name, "_busy"}, 32'(bif.bus_busy), 32'(b));
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 249) == 0);
        bif.tx_done = '0;
        for (int m = 0; m < MN; m++) begin
            if (drop_next[m]) begin
                bif.bus_req[m] = 1'b0;
                drop_next[m]   = 1'b0;
            end else if (!bif.bus_req[m]) begin
                bif.bus_req[m] = ($urandom_range(0, 2) == 0);
            end else if (m_owner == m && $urandom_range(0, 3) == 0) begin
                bif.tx_done[m] = 1'b1;
                drop_next[m]   = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                bif.bus_req[m] = 1'b0;
            end
        end
        bif.split_on = ($urandom_range(0, 4) == 0);
        bif.split_slave = '0;
        bif.split_slave[$urandom_range(0, SN - 1)] = 1'b1;
        for (int s = 0; s < SN; s++) bif.s_ready[s] = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bif.bus_req = '0; bif.tx_done = '0; bif.split_on = 1'b0;
        bif.split_slave = '0; bif.s_ready = '0;
        @(negedge clk);

        // Basic grant and release
        step(); lit("reset", 3'b000, 2'd0, 3'b000, 1'b0);
        rst = 1'b0; bif.bus_req = 3'b001;
        step(); lit("t1_grant", 3'b001, 2'd0, 3'b000, 1'b1);
        bif.tx_done = 3'b001;
        step(); lit("t1_done", 3'b000, 2'd0, 3'b000, 1'b0);
        bif.tx_done = '0; bif.bus_req = '0;
        step(); lit("t1_release", 3'b000, 2'd0, 3'b000, 1'b0);
        step(); lit("t1_idle", 3'b000, 2'd0, 3'b000, 1'b0);

        // Round-robin with pointer wrap
        rst = 1'b1; step(); rst = 1'b0;
        bif.bus_req = 3'b011;
        step(); lit("t2_g0", 3'b001, 2'd0, 3'b000, 1'b1);
        bif.tx_done = 3'b001;
        step(); lit("t2_rel0", 3'b000, 2'd0, 3'b000, 1'b0);
        bif.tx_done = '0;
        step(); lit("t2_gap0", 3'b000, 2'd0, 3'b000, 1'b0);
        step(); lit("t2_g1", 3'b010, 2'd1, 3'b000, 1'b1);
        bif.tx_done = 3'b010;
        step(); lit("t2_rel1", 3'b000, 2'd0, 3'b000, 1'b0);
        bif.tx_done = '0;
        step(); step(); lit("t2_wrap", 3'b001, 2'd0, 3'b000, 1'b1);

        // Split of M0, resume waits for M1's release
        bif.split_on = 1'b1; bif.split_slave = 3'b010;
        step(); lit("t3_park", 3'b000, 2'd0, 3'b001, 1'b0);
        bif.split_on = 1'b0;
        step(); step(); lit("t3_m1", 3'b010, 2'd1, 3'b001, 1'b1);
        bif.s_ready = 3'b010;
        step(); lit("t3_hold", 3'b010, 2'd1, 3'b001, 1'b1);
        bif.tx_done = 3'b010;
        step(); lit("t3_m1_done", 3'b000, 2'd0, 3'b001, 1'b0);
        bif.tx_done = '0;
        step(); lit("t3_rel", 3'b000, 2'd0, 3'b001, 1'b0);
        step(); lit("t3_resume", 3'b001, 2'd0, 3'b000, 1'b1);
        bif.s_ready = '0;

        // Second split while one is pending is ignored
        bif.split_on = 1'b1; bif.split_slave = 3'b010;
        step(); bif.split_on = 1'b0;
        step(); step(); lit("t4_m1", 3'b010, 2'd1, 3'b001, 1'b1);
        bif.split_on = 1'b1; bif.split_slave = 3'b001;
        step(); lit("t4_ignored", 3'b010, 2'd1, 3'b001, 1'b1);
        bif.split_on = 1'b0;

        // Reset mid-grant and mid-split
        rst = 1'b1;
        step(); lit("t6_reset", 3'b000, 2'd0, 3'b000, 1'b0);
        rst = 1'b0;
        step(); lit("t6_first", 3'b001, 2'd0, 3'b000, 1'b1);

        // tx_done beats split_on; same-cycle s_ready does not count
        bif.tx_done = 3'b001; bif.split_on = 1'b1; bif.split_slave = 3'b001;
        step(); lit("t5_done_wins", 3'b000, 2'd0, 3'b000, 1'b0);
        bif.tx_done = '0; bif.split_on = 1'b0;
        step(); step(); lit("t5_m1", 3'b010, 2'd1, 3'b000, 1'b1);
        bif.split_on = 1'b1; bif.split_slave = 3'b100; bif.s_ready = 3'b100;
        step(); lit("t5_park", 3'b000, 2'd0, 3'b010, 1'b0);
        bif.split_on = 1'b0; bif.s_ready = '0;
        step(); step(); lit("t5_no_early_resume", 3'b001, 2'd0, 3'b010, 1'b1);
        bif.s_ready = 3'b100;
        step(); lit("t5_hold", 3'b001, 2'd0, 3'b010, 1'b1);
        bif.tx_done = 3'b001;
        step(); bif.tx_done = '0; bif.s_ready = '0;
        step(); step(); lit("t5_resume", 3'b010, 2'd1, 3'b000, 1'b1);

        // Randomized traffic against the model
        bif.bus_req = '0; rst = 1'b1; step();
        for (int n = 0; n < 4000; n++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
